bcd_sum_display: RTL and testbench
==================================

Name: bcd_sum_display

Overview:
- Downstream consumer of the two-digit BCD adder.
- Captures the adder's 8-bit packed-BCD sum and decimal carry on a load strobe, and holds them as a 3-digit decimal value 000-199.
- Drives a time-multiplexed, active-low 3-digit seven-segment display, with optional leading-zero blanking and invalid-digit flagging.

Parameters:
- REFRESH_DIV, 4, clock cycles per digit slot; legal range >=2. Board builds use 100000; simulation uses 4.
- BLANK_LZ, 1, 1 = blank leading zeros on digits 2 and 1; 0 = always show all digits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- load  in  1  capture strobe, single-cycle or held.
- sum_in  in  8  packed BCD: [7:4] tens, [3:0] ones.
- carry_in  in  1  decimal carry (hundreds digit, 0 or 1).
- seg  out  7  active-low segments, bit order {g,f,e,d,c,b,a}; registered.
- an  out  3  active-low digit enables: an[2] hundreds, an[1] tens, an[0] ones; registered.
- val  out  9  held value {carry, tens, ones}; registered.
- err  out  1  high while either held nibble is >9; registered.

Behaviour:
- Reset, sampled when rst_n=0 at a clk edge:
  - val=0, err=0, seg=7'h7F, an=3'b111.
  - Refresh counter = 0; digit index = 0.
  - rst_n low mid-scan aborts the scan immediately at the next edge; no partial state survives.
- Capture:
  - load=1 at edge N: val <= {carry_in, sum_in}; err <= (sum_in[7:4]>9) | (sum_in[3:0]>9), also at edge N.
  - load=0: val and err hold.
  - Held load re-captures every cycle.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - On wrap, digit index advances 0->1->2->0. Index value 3 is unreachable; if forced, recover to 0 on the next advance.
- Output register (updated every cycle, from current index and current val):
  - an = one-hot-low of index (index 0 -> 3'b110, 1 -> 3'b101, 2 -> 3'b011).
  - seg = decoded digit for that index.
  - Latency: seg/an lag the index and val by exactly one cycle.
  - A load at edge N is visible on seg at edge N+1 if its digit is currently selected.
  - Simultaneous load and slot advance both take effect; the next seg uses the new index and the new val.
- Digit decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111, dash=0111111
- Digit rules:
  - Hundreds: shows 1 if carry=1; otherwise blank when BLANK_LZ=1, or 0 when BLANK_LZ=0.
  - Tens: blank only when BLANK_LZ=1, carry=0 and tens=0.
  - Ones: never blanked.
- Invalid nibble (>9): that digit shows dash. The digit is never blanked, and err stays high until a valid load or reset.
- Blank digits still assert their an bit; only seg is all-off.
- Counter widths: refresh counter is $clog2(REFRESH_DIV) bits; no overflow beyond the wrap.

Test Plan:
- Reset then release, REFRESH_DIV=4 -> every 4 cycles an steps 110,101,011,110; seg is 1000000 on an=110 and 1111111 on the other two digits; val=0, err=0.
- load with sum_in=8'h95, carry_in=1 -> val=9'h195; digits 2/1/0 show 1111001/0010000/0010010; err=0.
- BLANK_LZ=1, load sum_in=8'h07, carry_in=0 -> digits 2 and 1 blank (1111111), digit 0 = 1111000.
- BLANK_LZ=0 with the same load -> digit 2 = 1000000, digit 1 = 1000000, digit 0 = 1111000.
- load sum_in=8'hA3 -> err=1 the edge after load; tens shows 0111111, ones shows 0110000. A following load of 8'h42 clears err.
- rst_n low for one cycle mid-scan with val=9'h188 -> next edge: an=111, seg=7F, val=0, err=0; scan restarts at digit 0 with a full REFRESH_DIV period.

Source files
------------

// File: rtl/bcd_sum_display.sv
// Holds a captured BCD sum (000-199) and scans it onto an active-low 3-digit
// seven-segment display, with optional leading-zero blanking and invalid-digit dashes.
module bcd_sum_display #(
    parameter int unsigned REFRESH_DIV = 4,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] sum_in,
    input  logic       carry_in,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic [8:0] val,
    output logic       err
);

    localparam int unsigned    CntW     = $clog2(REFRESH_DIV);
    localparam logic [CntW-1:0] CntMax  = CntW'(REFRESH_DIV - 1);
    localparam logic [6:0]     SegBlank = 7'b1111111;
    localparam logic [6:0]     SegDash  = 7'b0111111;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [8:0]      val_q, val_d;
    logic            err_q, err_d;
    logic [6:0]      seg_q, seg_d;
    logic [2:0]      an_q, an_d;

    // Non-decimal nibbles fall through to the dash pattern.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = SegDash;
        endcase
    endfunction

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        idx_d = idx_q;
        if (cnt_q == CntMax) begin
            cnt_d = '0;
            case (idx_q)
                2'd0:    idx_d = 2'd1;
                2'd1:    idx_d = 2'd2;
                default: idx_d = 2'd0;
            endcase
        end

        val_d = val_q;
        err_d = err_q;
        if (load) begin
            val_d = {carry_in, sum_in};
            err_d = (sum_in[7:4] > 4'd9) | (sum_in[3:0] > 4'd9);
        end

        // Display is driven from the current index and held value, one cycle behind.
        an_d  = 3'b111;
        seg_d = SegBlank;
        case (idx_q)
            2'd0: begin
                an_d  = 3'b110;
                seg_d = seg_of(val_q[3:0]);
            end
            2'd1: begin
                an_d = 3'b101;
                if (val_q[7:4] > 4'd9) begin
                    seg_d = SegDash;
                end else if (BLANK_LZ && !val_q[8] && val_q[7:4] == 4'd0) begin
                    seg_d = SegBlank;
                end else begin
                    seg_d = seg_of(val_q[7:4]);
                end
            end
            2'd2: begin
                an_d = 3'b011;
                if (val_q[8]) begin
                    seg_d = seg_of(4'd1);
                end else if (BLANK_LZ) begin
                    seg_d = SegBlank;
                end else begin
                    seg_d = seg_of(4'd0);
                end
            end
            default: begin
                an_d  = 3'b111;
                seg_d = SegBlank;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= 2'd0;
            val_q <= 9'd0;
            err_q <= 1'b0;
            seg_q <= SegBlank;
            an_q  <= 3'b111;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            val_q <= val_d;
            err_q <= err_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign val = val_q;
    assign err = err_q;

endmodule

// File: tb/tb_bcd_sum_display.sv
// Randomized bench for bcd_sum_display: two instances (blanking on/off) checked every cycle
// against a scan-time model, plus directed literal checks of the display patterns.
module tb_bcd_sum_display;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [7:0] sum_in = 8'h00;
    logic       carry_in = 1'b0;

    logic [6:0] seg_b, seg_nb;
    logic [2:0] an_b, an_nb;
    logic [8:0] val_b, val_nb;
    logic       err_b, err_nb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd_sum_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .load(load), .sum_in(sum_in), .carry_in(carry_in),
        .seg(seg_b), .an(an_b), .val(val_b), .err(err_b)
    );

    bcd_sum_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) u_nb (
        .clk(clk), .rst_n(rst_n), .load(load), .sum_in(sum_in), .carry_in(carry_in),
        .seg(seg_nb), .an(an_nb), .val(val_nb), .err(err_nb)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference pattern table for a single decimal digit; anything else is a dash.
    function automatic logic [6:0] pat(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        if (d >= 0 && d <= 9) return tbl[d];
        return 7'b0111111;
    endfunction

    function automatic logic [6:0] exp_digit(input int slot, input logic [8:0] v, input bit blank);
        int h = int'(v[8]);
        int t = int'(v[7:4]);
        int o = int'(v[3:0]);
        if (slot == 0) return pat(o);
        if (slot == 1) begin
            if (t > 9) return 7'b0111111;
            if (blank && h == 0 && t == 0) return 7'b1111111;
            return pat(t);
        end
        if (h == 1) return pat(1);
        return blank ? 7'b1111111 : pat(0);
    endfunction

    // Model: m_k counts edges since reset; the slot is just (m_k / DIV) mod 3.
    int         m_k = 0;
    logic [8:0] m_val = 9'd0;
    bit         m_live = 1'b0;
    logic [6:0] e_seg_b, e_seg_nb;
    logic [2:0] e_an;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_k      <= 0;
            m_val    <= 9'd0;
            m_live   <= 1'b1;
            e_seg_b  <= 7'h7F;
            e_seg_nb <= 7'h7F;
            e_an     <= 3'b111;
        end else if (m_live) begin
            e_seg_b  <= exp_digit((m_k / DIV) % 3, m_val, 1'b1);
            e_seg_nb <= exp_digit((m_k / DIV) % 3, m_val, 1'b0);
            e_an     <= ~(3'b001 << ((m_k / DIV) % 3));
            m_k      <= m_k + 1;
            if (load) m_val <= {carry_in, sum_in};
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("seg_blank", 16'(seg_b), 16'(e_seg_b));
            check("seg_noblank", 16'(seg_nb), 16'(e_seg_nb));
            check("an", 16'({an_b, an_nb}), 16'({e_an, e_an}));
            check("val", 16'({val_b, 7'd0} | 16'(val_nb)), 16'({m_val, 7'd0} | 16'(m_val)));
            check("err", 16'({err_b, err_nb}),
                  16'({2{(m_val[7:4] > 4'd9) || (m_val[3:0] > 4'd9)}}));
        end
    end

    // Called at a negedge; leaves the new value visible on seg before returning.
    task automatic do_load(input logic [7:0] s, input logic c);
        sum_in   = s;
        carry_in = c;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_an(input logic [2:0] tgt);
        int n = 0;
        while (an_b !== tgt && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_an_timeout", 16'(an_b), 16'(tgt));
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_seg", 16'(seg_b), 16'h7F);
        check("rst_an", 16'(an_b), 16'b111);
        rst_n = 1'b1;

        // Zero value: only the ones digit lights on the blanking instance.
        wait_an(3'b110);
        check("zero_ones", 16'(seg_b), 16'b1000000);
        wait_an(3'b101);
        check("zero_tens_blank", 16'(seg_b), 16'b1111111);
        wait_an(3'b011);
        check("zero_hund_blank", 16'(seg_b), 16'b1111111);

        do_load(8'h95, 1'b1);
        check("val_195", 16'(val_b), 16'h195);
        wait_an(3'b011);
        check("h195", 16'(seg_b), 16'b1111001);
        wait_an(3'b101);
        check("t195", 16'(seg_b), 16'b0010000);
        wait_an(3'b110);
        check("o195", 16'(seg_b), 16'b0010010);

        do_load(8'h07, 1'b0);
        wait_an(3'b011);
        check("h007_b", 16'(seg_b), 16'b1111111);
        check("h007_nb", 16'(seg_nb), 16'b1000000);
        wait_an(3'b101);
        check("t007_b", 16'(seg_b), 16'b1111111);
        check("t007_nb", 16'(seg_nb), 16'b1000000);
        wait_an(3'b110);
        check("o007", 16'(seg_b), 16'b1111000);

        do_load(8'hA3, 1'b0);
        check("err_a3", 16'(err_b), 16'd1);
        wait_an(3'b101);
        check("tA3_dash", 16'(seg_b), 16'b0111111);
        wait_an(3'b110);
        check("oA3", 16'(seg_b), 16'b0110000);
        do_load(8'h42, 1'b0);
        check("err_clear", 16'(err_b), 16'd0);

        do_load(8'h88, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_an", 16'(an_b), 16'b111);
        check("midrst_seg", 16'(seg_b), 16'h7F);
        check("midrst_val", 16'(val_b), 16'h000);
        check("midrst_err", 16'(err_b), 16'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("restart_slot0", 16'(an_b), 16'b110);
        end
        @(negedge clk);
        check("restart_slot1", 16'(an_b), 16'b101);

        for (int i = 0; i < 3000; i++) begin
            rst_n    = ($urandom_range(0, 299) != 0);
            load     = ($urandom_range(0, 3) == 0);
            carry_in = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) sum_in = 8'($urandom_range(0, 255));
            else sum_in = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            @(negedge clk);
        end
        rst_n = 1'b1;
        load  = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
